// File: rtl/wave_mixer_if.sv
// rtl/wave_mixer_if.sv - waveform-in / PWM-out bundle between the function generator and wave_mixer
//
// Signals:
//   Enable_SW   [3:0]          channel enables: [0] sine, [1] saw, [2] tri, [3] square
//   Pulse_in    [3:0]          1-bit waveform streams, same bit order as Enable_SW
//   Mix_out                    PWM output of the mixed level
//   Mix_level   [WIN_BITS-1:0] most recent mixed level
//   Level_valid                one-cycle strobe when Mix_level updates
// Modports:
//   master - waveform source side (drives Enable_SW/Pulse_in)
//   slave  - mixer side (drives Mix_out/Mix_level/Level_valid)

interface wave_mixer_if #(
    parameter int WIN_BITS = 8
);
    logic [3:0]          Enable_SW;
    logic [3:0]          Pulse_in;
    logic                Mix_out;
    logic [WIN_BITS-1:0] Mix_level;
    logic                Level_valid;

    modport master (
        output Enable_SW,
        output Pulse_in,
        input  Mix_out,
        input  Mix_level,
        input  Level_valid
    );

    modport slave (
        input  Enable_SW,
        input  Pulse_in,
        output Mix_out,
        output Mix_level,
        output Level_valid
    );
endinterface

// File: rtl/wave_mixer.sv
// rtl/wave_mixer.sv - averages enabled waveform duty cycles over a window and re-emits them as PWM
//
// Ports:
//   sysclk  in   system clock, all logic on posedge
//   reset   in   asynchronous active-low reset
//   bus     slave modport of wave_mixer_if:
//             Enable_SW/Pulse_in in (asynchronous, synchronised here)
//             Mix_out/Mix_level/Level_valid out (all registered)
// Parameters:
//   WIN_BITS  log2 of the measurement window in sysclk cycles, also the PWM resolution (4..12)

module wave_mixer #(
    parameter int WIN_BITS = 8
) (
    input  logic        sysclk,
    input  logic        reset,
    wave_mixer_if.slave bus
);

    localparam int SUM_W = WIN_BITS + 3;
    localparam logic [WIN_BITS-1:0] WCNT_MAX = '1;

    // Two-flop synchronisers for the asynchronous waveform and enable inputs
    logic [3:0] p_meta;
    logic [3:0] p;
    logic [3:0] en_meta;
    logic [3:0] en;

    // Window timing / accumulation state
    logic [WIN_BITS-1:0] wcnt;
    logic [3:0]          mask;
    logic [WIN_BITS:0]   cnt [4];

    // Registered outputs
    logic                mix_out_q;
    logic [WIN_BITS-1:0] level_q;
    logic                valid_q;

    // Combinational helpers
    logic                win_close;
    logic [WIN_BITS-1:0] wcnt_next;
    logic [3:0]          hit;
    logic [SUM_W-1:0]    sum;
    logic [2:0]          n_en;
    logic [1:0]          shift;
    logic [SUM_W-1:0]    shifted;
    logic [WIN_BITS-1:0] level_sat;
    logic [WIN_BITS-1:0] level_next;

    assign win_close = (wcnt == WCNT_MAX);
    // Natural wrap of the WIN_BITS-wide counter gives the free-running window/carrier
    assign wcnt_next = wcnt + 1'b1;
    assign hit       = mask & p;

    // Window total includes the sample taken on the closing edge itself,
    // which the channel counters have not yet absorbed.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + {2'b00, cnt[i]} + {{(SUM_W-1){1'b0}}, hit[i]};
        end
    end

    assign n_en = {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};

    // Divide by 1/2/4 for 0-1/2/3-4 channels; three channels are left
    // underscaled by 3/4 on purpose to match the generator's clip factor.
    always_comb begin
        shift = 2'd0;
        case (n_en)
            3'd0, 3'd1: shift = 2'd0;
            3'd2:       shift = 2'd1;
            default:    shift = 2'd2;
        endcase
    end

    assign shifted = sum >> shift;

    // Any bit at or above WIN_BITS means the average reached 2^WIN_BITS;
    // clamp so the PWM never tries for 100% duty.
    assign level_sat = (|shifted[SUM_W-1:WIN_BITS]) ? WCNT_MAX : shifted[WIN_BITS-1:0];

    // Level only moves at a window close, so the PWM period that starts at
    // wcnt==0 always sees one consistent level.
    assign level_next = win_close ? level_sat : level_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            p_meta    <= '0;
            p         <= '0;
            en_meta   <= '0;
            en        <= '0;
            wcnt      <= '0;
            mask      <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            mix_out_q <= 1'b0;
            level_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            p_meta  <= bus.Pulse_in;
            p       <= p_meta;
            en_meta <= bus.Enable_SW;
            en      <= en_meta;

            wcnt <= wcnt_next;

            // Mask is frozen for a whole window so counts and divisor agree
            if (win_close) begin
                mask <= en;
            end

            for (int i = 0; i < 4; i++) begin
                if (win_close) begin
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end

            level_q   <= level_next;
            valid_q   <= win_close;
            // Compare against next-cycle carrier and level so Mix_out during
            // wcnt==k is exactly (k < Mix_level).
            mix_out_q <= (wcnt_next < level_next);
        end
    end

    assign bus.Mix_out     = mix_out_q;
    assign bus.Mix_level   = level_q;
    assign bus.Level_valid = valid_q;

endmodule

// File: tb/tb_wave_mixer.sv
// tb/tb_wave_mixer.sv - scoreboard bench for wave_mixer with WIN_BITS=4

module tb_wave_mixer;

    localparam int WB   = 4;
    localparam int N    = 16;
    localparam int HMAX = 8192;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;

    wave_mixer_if #(.WIN_BITS(WB)) bus ();

    wave_mixer #(.WIN_BITS(WB)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int tests = 0;
    int fails = 0;

    // Rising edges since reset release; wcnt during the cycle after edge k is k mod N
    int edges = 0;
    always @(posedge sysclk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    int         exp_q[$];
    int         e = 0;
    logic [3:0] h_en [HMAX];
    logic [3:0] h_p  [HMAX];
    int         cur_level = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] en_at(input int idx);
        return (idx < 1) ? 4'd0 : h_en[idx];
    endfunction

    function automatic logic [3:0] p_at(input int idx);
        return (idx < 1) ? 4'd0 : h_p[idx];
    endfunction

    // Window k spans edges (k-1)N+1..kN. Inputs are seen two edges late; the
    // mask is the enable seen at the previous window's last edge (0 for k=1).
    function automatic int model_level(input int k);
        logic [3:0] m;
        logic [3:0] pv;
        int sum, n, lv;
        m   = (k == 1) ? 4'd0 : en_at((k - 1) * N - 2);
        sum = 0;
        for (int ed = (k - 1) * N + 1; ed <= k * N; ed++) begin
            pv = p_at(ed - 2);
            for (int i = 0; i < 4; i++) begin
                if (m[i] && pv[i]) sum++;
            end
        end
        n  = $countones(m);
        lv = (n <= 1) ? sum : (n == 2) ? sum / 2 : sum / 4;
        if (lv > N - 1) lv = N - 1;
        return lv;
    endfunction

    // Drive inputs for the next edge, record them, and push the expected level
    // as soon as the window it completes is fully determined.
    task automatic step(input logic [3:0] en, input logic [3:0] p);
        e++;
        if (e >= HMAX) begin
            $display("FAIL history_overflow: got %0d expected below %0d", e, HMAX);
            $fatal(1, "history overflow");
        end
        h_en[e]       = en;
        h_p[e]        = p;
        bus.Enable_SW = en;
        bus.Pulse_in  = p;
        if (e >= N - 2 && (e + 2) % N == 0) exp_q.push_back(model_level((e + 2) / N));
        @(negedge sysclk);
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            bus.Enable_SW = 4'($urandom);
            bus.Pulse_in  = 4'($urandom);
            @(negedge sysclk);
        end
        reset = 1'b1;
        e     = 0;
    endtask

    // Step until the next Level_valid, then compare the published level with a fixed value.
    task automatic expect_level(input string name, input int exp, input logic [3:0] en,
                                input logic [3:0] p0, input logic [3:0] p1, output int nsteps);
        bit found;
        found  = 0;
        nsteps = 0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            step(en, ((e + 1) % 2 == 0) ? p0 : p1);
            nsteps++;
            #1;
            if (bus.Level_valid) begin
                check(name, int'(bus.Mix_level), exp);
                found = 1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no Level_valid expected one within %0d cycles", name, 2 * N + 2);
        end
    endtask

    task automatic run(input int cycles, input logic [3:0] en, input logic [3:0] p0, input logic [3:0] p1);
        repeat (cycles) step(en, ((e + 1) % 2 == 0) ? p0 : p1);
    endtask

    // Monitor: checks every cycle against the scoreboard, independent of the stimulus
    initial begin
        bit exp_v;
        int ev;
        forever begin
            @(negedge sysclk);
            #1;
            if (!reset) begin
                check("rst_mix_out", int'(bus.Mix_out), 0);
                check("rst_mix_level", int'(bus.Mix_level), 0);
                check("rst_level_valid", int'(bus.Level_valid), 0);
                cur_level = 0;
            end else begin
                exp_v = (edges > 0) && (edges % N == 0);
                check("level_valid", int'(bus.Level_valid), int'(exp_v));
                if (exp_v) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard_empty: got a window close expected a queued level");
                    end else begin
                        ev = exp_q.pop_front();
                        check("mix_level", int'(bus.Mix_level), ev);
                        cur_level = ev;
                    end
                end else begin
                    check("mix_level_hold", int'(bus.Mix_level), cur_level);
                end
                check("mix_out", int'(bus.Mix_out), int'((edges % N) < cur_level));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        logic [3:0] ren;
        bus.Enable_SW = 4'd0;
        bus.Pulse_in  = 4'd0;

        // Held in reset with toggling inputs, then first-window latency and level
        hold_reset(5);
        expect_level("first_level", 0, 4'b1000, 4'b1000, 4'b1000, ns);
        check("first_valid_latency", ns, N);

        // Single channel saturation
        run(2 * N, 4'b1000, 4'b1000, 4'b1000);
        expect_level("single_sat", 15, 4'b1000, 4'b1000, 4'b1000, ns);
        check("valid_period", ns, N);

        // Two-channel average
        run(2 * N, 4'b0011, 4'b0001, 4'b0001);
        expect_level("two_ch_avg", 8, 4'b0011, 4'b0001, 4'b0001, ns);

        // Three-channel clip, constant and with sine toggling every cycle
        run(2 * N, 4'b0111, 4'b0111, 4'b0111);
        expect_level("three_ch_clip", 12, 4'b0111, 4'b0111, 4'b0111, ns);
        run(2 * N, 4'b0111, 4'b0111, 4'b0110);
        expect_level("three_ch_toggle", 10, 4'b0111, 4'b0111, 4'b0110, ns);

        // Enable change mid-window (wcnt==5): that window keeps the old mask
        run(2 * N, 4'b0001, 4'b1111, 4'b1111);
        while (e % N != 5) step(4'b0001, 4'b1111);
        expect_level("mid_en_old_mask", 15, 4'b1111, 4'b1111, 4'b1111, ns);
        expect_level("mid_en_four_sat", 15, 4'b1111, 4'b1111, 4'b1111, ns);
        run(2 * N, 4'b0001, 4'b0001, 4'b0001);
        while (e % N != 5) step(4'b0001, 4'b0001);
        expect_level("mid_en_old_mask2", 15, 4'b1111, 4'b0001, 4'b0001, ns);
        expect_level("mid_en_quarter", 4, 4'b1111, 4'b0001, 4'b0001, ns);

        // Mask of zero holds the output low
        run(2 * N, 4'b0000, 4'b1111, 4'b1111);
        expect_level("mask_zero", 0, 4'b0000, 4'b1111, 4'b1111, ns);

        // Asynchronous reset at wcnt==9 while Mix_out is high
        run(2 * N, 4'b1000, 4'b1000, 4'b1000);
        while (e % N != 9) step(4'b1000, 4'b1000);
        #2;
        check("pre_reset_mix_out", int'(bus.Mix_out), 1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_mix_out", int'(bus.Mix_out), 0);
        check("async_mix_level", int'(bus.Mix_level), 0);
        check("async_level_valid", int'(bus.Level_valid), 0);
        @(negedge sysclk);
        hold_reset(3);
        expect_level("recover_level", 0, 4'b0101, 4'b0101, 4'b0100, ns);
        check("recover_valid_latency", ns, N);

        // Randomised traffic, including enable changes at arbitrary phases
        ren = 4'($urandom);
        repeat (12 * N) begin
            if ($urandom_range(0, 7) == 0) ren = 4'($urandom);
            step(ren, 4'($urandom));
        end
        repeat (12 * N) begin
            if ($urandom_range(0, 11) == 0) ren = 4'($urandom);
            step(ren, 4'($urandom | $urandom));
        end
        run(N + 2, ren, 4'b1111, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wave_mixer.md
Name: wave_mixer

Overview:
- Downstream of the function-generator top level; consumes its four 1-bit waveform streams (sine, saw, tri, square) and the Enable_SW mask.
- Measures each enabled stream's high-time over a fixed window and averages the enabled channels using the same clip rule as the top level.
- Drives a single PWM output carrying the mixed level, for one output pin or a filter/DAC stage.

Parameters:
- WIN_BITS, 8, log2 of window length in sysclk cycles; also the PWM resolution. Legal range 4..12.

Ports:
- sysclk  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- Enable_SW  in  4  channel enables: [0] sine, [1] saw, [2] tri, [3] square.
- Pulse_in  in  4  waveform streams, same bit order as Enable_SW; asynchronous to the window timing.
- Mix_out  out  1  PWM output of the mixed level.
- Mix_level  out  WIN_BITS  most recent mixed level.
- Level_valid  out  1  one-cycle strobe when Mix_level updates.

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0 immediately, regardless of clock:
  - all registers, including synchronisers, window counter, channel counters and the enable snapshot;
  - Mix_out, Mix_level and Level_valid.
- Input sync: Pulse_in and Enable_SW each pass through a 2-flop synchroniser. Synchronised values are referred to as p[3:0] and en[3:0].
- Window counter:
  - wcnt is WIN_BITS wide, free-running 0..2^WIN_BITS-1, then wraps.
  - wcnt doubles as the PWM carrier counter.
- Enable snapshot:
  - mask <= en at each edge where wcnt==max (and 0 out of reset).
  - mask stays fixed for the whole following window, so counting and the divisor always agree.
- Channel counters:
  - cnt[i] is WIN_BITS+1 bits.
  - Each cycle, cnt[i] increments when mask[i] & p[i].
  - Maximum value is 2^WIN_BITS, which cannot overflow.
- Window close (edge where wcnt==max):
  - sum = sum of (cnt[i] + (mask[i]&p[i])) over i, including the final sample; sum is WIN_BITS+3 bits.
  - shift depends on popcount(mask):
    - 0 or 1 channels: shift 0;
    - 2 channels: shift 1;
    - 3 or 4 channels: shift 2 (same as the top-level clip factor 1/2/4).
  - Mix_level <= min(sum>>shift, 2^WIN_BITS-1), saturating.
  - All cnt[i] <= 0.
  - mask is reloaded as described under Enable snapshot.
  - Level_valid is 1 for exactly the next cycle (wcnt==0); it is 0 otherwise.
- PWM output:
  - Mix_out is registered: Mix_out <= (wcnt_next < Mix_level_next).
  - Result: during the cycle where wcnt==k, Mix_out = (k < Mix_level).
  - The new level takes effect from wcnt==0 of the window in which Level_valid is high; the level does not change mid-period.
- Boundaries:
  - mask==0: level 0, Mix_out held 0.
  - Level 2^WIN_BITS-1 gives duty (2^WIN_BITS-1)/2^WIN_BITS; 100% duty is unreachable by design.
  - A 3-channel average is deliberately underscaled by 3/4, matching the top-level clip rule.
- Latency:
  - An input change reaches p/en after 2 edges.
  - The first Level_valid after reset release comes at wcnt==0 of the second window, i.e. 2^WIN_BITS cycles after the first edge.
  - The first window's level is computed with mask=0 (the reset snapshot), so it is 0.
- Reset mid-window: state clears at once. On release, the bench sees the same behaviour as from power-up.

Test Plan (WIN_BITS=4, window = 16 cycles):
- Reset: hold reset=0, toggle Pulse_in/Enable_SW -> all outputs 0. Release -> Level_valid first high 16 cycles after release, with Mix_level=0.
- Single channel saturation: Enable_SW=1000, Pulse_in[3]=1 constant, past settling -> Mix_level=15, Mix_out high 15 of every 16 cycles, Level_valid once per 16 cycles.
- Two-channel average: Enable_SW=0011, Pulse_in[0]=1, Pulse_in[1]=0 -> sum 16>>1, Mix_level=8, Mix_out high during wcnt 0..7.
- Three-channel clip: Enable_SW=0111, Pulse_in=0111 -> sum 48>>2, Mix_level=12. Pulse_in[0] toggling every cycle, others 1 -> sum 40>>2 = 10.
- Mid-window enable change: Enable_SW 0001 -> 1111 at wcnt==5, Pulse_in=1111 -> that window's level uses mask 0001, giving 15; the next window gives 64>>2 = 16, saturated to 15. Repeat with Pulse_in=0001 -> next level 16>>2 = 4.
- Reset mid-operation: assert reset at wcnt==9 with Mix_out=1 -> Mix_out, Mix_level and Level_valid go to 0 without a clock edge; recovery matches the reset scenario.
